dma_rd_burst_gen: RTL
=====================

Name: dma_rd_burst_gen

Overview:
- DMA read engine that sits directly upstream of the shortcut stage.
- Accepts one read command (start address and byte length) per handshake and splits it into AXI4 INCR read bursts. Bursts are limited by a maximum burst length and never cross a 4 KB boundary.
- Returns R-channel data to the consumer in order; dma_rlast marks only the final beat of the whole command.
- Tracks and limits the number of outstanding bursts.

Parameters:
- AXI_DW, 128, AXI data width in bits; bytes per beat BPB = AXI_DW/8, L = log2(BPB).
- AXI_AW, 32, AXI address width.
- MAX_BURST, 16, maximum beats per burst (power of 2, ≤256); matches the consumer's R buffer depth.
- MAX_OUTSTANDING, 4, maximum bursts issued but not yet completed.

Ports:
- usr_clk  in  1  clock
- usr_reset_n  in  1  async active-low reset
- dmar_valid  in  1  command valid
- dmar_ready  out  1  command ready
- dmar_sa  in  32  start byte address
- dmar_len  in  32  length in bytes
- m_arvalid  out  1  AR valid
- m_arready  in  1  AR ready
- m_araddr  out  AXI_AW  burst address
- m_arlen  out  8  beats-1
- m_arsize  out  3  fixed L
- m_arburst  out  2  fixed INCR (01)
- m_rdata  in  AXI_DW  R data
- m_rresp  in  2  R response
- m_rlast  in  1  R last beat of burst
- m_rvalid  in  1  R valid
- m_rready  out  1  R ready
- dma_rdata  out  AXI_DW  data to consumer
- dma_rlast  out  1  last beat of command
- dma_rvalid  out  1  data valid
- dma_rready  in  1  consumer ready
- rd_err  out  1  sticky error flag

Behaviour:
- Reset is usr_reset_n, asynchronous, active-low; clock is usr_clk.
- Reset values: state IDLE, m_arvalid 0, rd_err 0, all counters 0; dmar_ready is 1 after reset.
- m_arsize = L and m_arburst = 01 are constant.
- States: IDLE, ADDR, DRAIN.
- dmar_ready = (state == IDLE).
- On dmar_valid & dmar_ready:
  - addr = dmar_sa with the low L bits cleared.
  - beats = ceil(dmar_len / BPB), computed at 32-bit width.
  - rd_err is cleared.
  - burst_rem (bursts still to be received) = 0.
  - If beats == 0: stay in IDLE and set rd_err (zero-length command); no AR is issued.
  - Otherwise go to ADDR.
- Burst size: blen = min(MAX_BURST, (4096 - addr[11:0]) >> L, beats_rem). It is computed combinationally from registered addr/beats_rem, using 13-bit arithmetic for the 4 KB term.
- ADDR state:
  - m_arvalid = 1 when outstanding < MAX_OUTSTANDING.
  - m_araddr and m_arlen (= blen-1) are registered and held stable until m_arready.
- On AR handshake:
  - addr += blen << L; beats_rem -= blen; outstanding++; burst_rem++.
  - When beats_rem reaches 0, go to DRAIN.
- One AR handshake at most per cycle; AR issue latency is 1 cycle after command accept.
- R path is combinational pass-through, zero latency:
  - dma_rdata = m_rdata.
  - dma_rvalid = m_rvalid & (state != IDLE).
  - m_rready = dma_rready & (state != IDLE).
- End of burst (m_rvalid & m_rready & m_rlast): outstanding--, burst_rem--.
- If AR handshake and end of burst occur in the same cycle, outstanding and burst_rem net to unchanged.
- dma_rlast = m_rvalid & m_rlast & (state == DRAIN) & (burst_rem == 1).
- When the dma_rlast beat is accepted: return to IDLE; dmar_ready rises the next cycle.
- A beat with m_rresp != 00 sets rd_err (sticky until the next command accept). Its data is still forwarded; the burst count is unaffected.
- m_rvalid while IDLE is ignored (m_rready low).
- Reset mid-operation aborts immediately. Outstanding AXI transactions are lost; the interconnect must be reset together with this block.

Decomposition:
- dma_pkg holds:
  - AXI_BURST_INCR = 2'b01.
  - AXI_RESP_OKAY = 2'b00.
  - BOUNDARY_4K = 4096.
  - typedef dma_cmd_t {sa, len}.
  - typedef st_rd_e {IDLE, ADDR, DRAIN}.
- One sub-module: dma_burst_calc, a combinational blen/4 KB-boundary calculator parameterised by AXI_DW and MAX_BURST. It is reused by the write engine.

Test Plan (AXI_DW = 128, BPB = 16):
- Single burst: sa=0x1000, len=256, arready=1 → one AR with araddr=0x1000, arlen=15. dma_rlast on beat 16 only. dmar_ready high 1 cycle after that beat.
- 4 KB split: sa=0x0F80, len=512 → three ARs: (0x0F80, arlen 7), (0x1000, 15), (0x1100, 7). 32 beats in order; dma_rlast only on beat 32.
- Outstanding limit and misalignment:
  - sa=0, len=2048, rvalid held 0 → exactly 4 ARs issued; the 5th AR is issued only after the 1st burst's rlast is accepted. Total 8 ARs; dma_rlast on beat 128.
  - sa=0x1008, len=20 → araddr 0x1000, arlen 1 (2 beats).
- Backpressure: dma_rready random 50% → m_rready mirrors it each cycle. No beat is lost or duplicated; data order matches the AXI slave model.
- Errors:
  - m_rresp=SLVERR on beat 3 → rd_err=1, all beats still delivered; rd_err cleared on the next command accept.
  - len=0 → accepted, no AR issued, rd_err=1, state remains IDLE.

Source files
------------

// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
//   Shared definitions for the DMA read/write engines: AXI burst/response
//   encodings, the 4 KB boundary constant, the command record and the read
//   engine state type.
// ---------------------------------------------------------------------------
package dma_pkg;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned BOUNDARY_4K    = 4096;

  // One DMA command as presented on the dmar_* port.
  typedef struct packed {
    logic [31:0] sa;   // start byte address
    logic [31:0] len;  // length in bytes
  } dma_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DRAIN
  } st_rd_e;

endpackage : dma_pkg

// File: rtl/dma_burst_calc.sv
// ---------------------------------------------------------------------------
// dma_burst_calc
//   Combinational burst length calculator shared by the DMA engines.
//   blen = min(MAX_BURST, beats left before the next 4 KB boundary, beats_rem)
//
//   addr_lo    in  12  low 12 bits of the (beat aligned) burst address
//   beats_rem  in  32  beats still to be requested for the command
//   blen       out  9  beats in the next burst (0 when beats_rem is 0)
// ---------------------------------------------------------------------------
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int unsigned AXI_DW    = 128,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic [11:0] addr_lo,
  input  logic [31:0] beats_rem,
  output logic [8:0]  blen
);

  localparam int unsigned BPB = AXI_DW / 8;
  localparam int unsigned L   = $clog2(BPB);

  logic [12:0] room;  // beats until the 4 KB boundary, 13 bits so 4096 fits
  logic [12:0] cap;

  assign room = (13'(BOUNDARY_4K) - {1'b0, addr_lo}) >> L;

  always_comb begin
    cap = 13'(MAX_BURST);
    if (room < cap) begin
      cap = room;
    end
    if (beats_rem < {19'b0, cap}) begin
      blen = beats_rem[8:0];
    end else begin
      blen = cap[8:0];
    end
  end

endmodule : dma_burst_calc

// File: rtl/dma_rd_burst_gen.sv
// ---------------------------------------------------------------------------
// dma_rd_burst_gen
//   DMA read engine. Accepts one {start address, byte length} command per
//   handshake, splits it into AXI4 INCR read bursts (max MAX_BURST beats,
//   never crossing 4 KB), limits outstanding bursts to MAX_OUTSTANDING and
//   forwards R data to the consumer in order with zero latency. dma_rlast
//   marks only the final beat of the whole command.
//
//   usr_clk / usr_reset_n          clock, async active-low reset
//   dmar_valid/ready/sa/len        command handshake
//   m_ar*                          AXI read address channel (master)
//   m_r*                           AXI read data channel (master)
//   dma_rdata/rlast/rvalid/rready  data stream to the consumer
//   rd_err                         sticky error (zero-length command or
//                                  non-OKAY response), cleared on accept
// ---------------------------------------------------------------------------
module dma_rd_burst_gen
  import dma_pkg::*;
#(
  parameter int unsigned AXI_DW          = 128,
  parameter int unsigned AXI_AW          = 32,
  parameter int unsigned MAX_BURST       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic              usr_clk,
  input  logic              usr_reset_n,
  // command
  input  logic              dmar_valid,
  output logic              dmar_ready,
  input  logic [31:0]       dmar_sa,
  input  logic [31:0]       dmar_len,
  // AXI AR
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [AXI_AW-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  // AXI R
  input  logic [AXI_DW-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  // consumer
  output logic [AXI_DW-1:0] dma_rdata,
  output logic              dma_rlast,
  output logic              dma_rvalid,
  input  logic              dma_rready,
  output logic              rd_err
);

  localparam int unsigned BPB = AXI_DW / 8;
  localparam int unsigned L   = $clog2(BPB);
  localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);

  st_rd_e            state_q;
  st_rd_e            state_d;
  logic [AXI_AW-1:0] addr_q;
  logic [31:0]       beats_rem_q;
  logic [OW-1:0]     outstanding_q;
  logic [OW-1:0]     burst_rem_q;
  logic              rd_err_q;

  dma_cmd_t          cmd;
  logic [31:0]       cmd_beats;
  logic [AXI_AW-1:0] cmd_addr;
  logic [8:0]        blen;

  logic              cmd_accept;
  logic              ar_hs;
  logic              r_hs;
  logic              burst_end;
  logic              last_hs;
  logic              busy;

  // -------------------------------------------------------------------------
  // Command decode
  // -------------------------------------------------------------------------
  assign cmd = '{sa: dmar_sa, len: dmar_len};

  // ceil(len / BPB) without the overflow of (len + BPB - 1)
  assign cmd_beats = (cmd.len >> L) + 32'(|cmd.len[L-1:0]);
  assign cmd_addr  = AXI_AW'(cmd.sa) & ~AXI_AW'(BPB - 1);

  // -------------------------------------------------------------------------
  // Burst sizing from the registered address / remaining beats
  // -------------------------------------------------------------------------
  dma_burst_calc #(
    .AXI_DW   (AXI_DW),
    .MAX_BURST(MAX_BURST)
  ) u_burst_calc (
    .addr_lo  (addr_q[11:0]),
    .beats_rem(beats_rem_q),
    .blen     (blen)
  );

  // -------------------------------------------------------------------------
  // Handshakes
  // -------------------------------------------------------------------------
  assign busy       = (state_q != IDLE);
  assign cmd_accept = dmar_valid & dmar_ready;
  assign ar_hs      = m_arvalid & m_arready;
  assign r_hs       = m_rvalid & m_rready;
  assign burst_end  = r_hs & m_rlast;
  assign last_hs    = dma_rlast & dma_rready;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dmar_ready = 1'b0;
    m_arvalid  = 1'b0;
    case (state_q)
      IDLE: begin
        dmar_ready = 1'b1;
        if (cmd_accept && (cmd_beats != 32'd0)) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        m_arvalid = (outstanding_q < OW'(MAX_OUTSTANDING));
        if (ar_hs && (beats_rem_q == 32'(blen))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Address / beat bookkeeping
  // -------------------------------------------------------------------------
  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      addr_q      <= '0;
      beats_rem_q <= '0;
    end else if (cmd_accept) begin
      addr_q      <= cmd_addr;
      beats_rem_q <= cmd_beats;
    end else if (ar_hs) begin
      addr_q      <= addr_q + (AXI_AW'(blen) << L);
      beats_rem_q <= beats_rem_q - 32'(blen);
    end
  end

  // outstanding and burst_rem move together; an AR and a burst end in the
  // same cycle cancel out
  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      outstanding_q <= '0;
      burst_rem_q   <= '0;
    end else begin
      case ({ar_hs, burst_end})
        2'b10: begin
          outstanding_q <= outstanding_q + OW'(1);
          burst_rem_q   <= burst_rem_q + OW'(1);
        end
        2'b01: begin
          outstanding_q <= outstanding_q - OW'(1);
          burst_rem_q   <= burst_rem_q - OW'(1);
        end
        default: begin
          outstanding_q <= outstanding_q;
          burst_rem_q   <= burst_rem_q;
        end
      endcase
      if (cmd_accept) begin
        burst_rem_q <= '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sticky error
  // -------------------------------------------------------------------------
  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      rd_err_q <= 1'b0;
    end else if (cmd_accept) begin
      rd_err_q <= (cmd_beats == 32'd0);
    end else if (r_hs && (m_rresp != AXI_RESP_OKAY)) begin
      rd_err_q <= 1'b1;
    end
  end

  assign rd_err = rd_err_q;

  // -------------------------------------------------------------------------
  // AR channel outputs
  // -------------------------------------------------------------------------
  assign m_araddr  = addr_q;
  assign m_arlen   = 8'(blen - 9'd1);
  assign m_arsize  = 3'(L);
  assign m_arburst = AXI_BURST_INCR;

  // -------------------------------------------------------------------------
  // R pass-through
  // -------------------------------------------------------------------------
  assign dma_rdata  = m_rdata;
  assign dma_rvalid = m_rvalid & busy;
  assign m_rready   = dma_rready & busy;
  assign dma_rlast  = m_rvalid & m_rlast & (state_q == DRAIN) &
                      (burst_rem_q == OW'(1));

endmodule : dma_rd_burst_gen
